mux_arbiter_4: RTL and testbench
================================

MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

Interface
REQ-001 Parameter W, default 8, is the data width of each requester and of the shared output.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  is the reset, synchronous and active-high.
REQ-004 in_valid  input  4  bit i is set when requester i offers data.
REQ-005 in_data  input  4*W  is requester i data on bits [i*W +: W].
REQ-006 in_ready  output  4  bit i is set when requester i's data is accepted this cycle.
REQ-007 out_valid  output  1  is set when the output register holds an unconsumed word.
REQ-008 out_data  output  W  is the held word.
REQ-009 out_src  output  2  is the index of the requester that supplied out_data.
REQ-010 out_ready  input  1  is set when the consumer accepts the word this cycle.

Function
REQ-011 The block SHALL share one 4:1 data mux between four requesters, with a single registered output stage.
REQ-012 Internal state SHALL be a 2-bit priority pointer ptr plus the output register (out_valid, out_data, out_src).
REQ-013 load SHALL be defined as (!out_valid || out_ready): the output register is empty or draining this cycle.
REQ-014 grant SHALL be the first index with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-015 in_ready SHALL be one-hot at bit grant when load=1 and in_valid is nonzero, and all-zero otherwise.
REQ-016 in_ready SHALL be combinational from in_valid, ptr, out_valid and out_ready, with no register in that path.
REQ-017 On a clock where load=1 and in_valid!=0, the block SHALL set out_data to in_data[grant], out_src to grant, out_valid to 1, and ptr to grant+1 mod 4 (wrapping from 3 to 0).
REQ-018 On a clock where load=1 and in_valid=0, the block SHALL clear out_valid and SHALL leave out_data, out_src and ptr unchanged.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_src, out_valid and ptr SHALL hold, and in_ready SHALL be 0.
REQ-020 Latency SHALL be 1 cycle from an input handshake to out_valid.
REQ-021 With out_ready held at 1, throughput SHALL be one word per cycle, with no bubble between back-to-back transfers.
REQ-022 Simultaneous drain and refill (out_valid=1, out_ready=1, in_valid!=0) SHALL consume the old word and load the new word on the same edge.
REQ-023 Fairness: a requester holding in_valid=1 SHALL be granted within 4 consecutive load cycles that carry a transfer.
REQ-024 The block SHALL transfer exactly one word per input handshake, with no duplication and no loss.
REQ-025 Requesters SHALL keep in_valid and in_data stable until their in_ready bit is seen; the block does not check this.

Reset
REQ-026 With rst=1 at a clock edge, out_valid, out_data, out_src and ptr SHALL all become 0.
REQ-027 While rst=1, in_ready SHALL be 0; reset overrides any handshake in the same cycle, and that word is not accepted.
REQ-028 Reset mid-operation SHALL discard the held word, and after release arbitration SHALL restart from requester 0.

Verification
REQ-029 Reset then single request: in_valid=4'b0100 with in_data lane 2=8'hA5 and out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_src=2, ptr=3.
REQ-030 All requesting with out_ready=1 for 8 cycles, lanes i=8'h10+i -> out_src sequence 0,1,2,3,0,1,2,3 and in_ready one-hot rotating in the same order.
REQ-031 Back-pressure: after a load, out_ready=0 for 3 cycles -> out_data and out_src stable, in_ready=0 throughout; out_ready=1 -> next grant is (previous out_src+1) mod 4 if that requester is valid.
REQ-032 Wrap and skip: ptr=3 with in_valid=4'b0010 -> grant=1 and ptr becomes 2; then in_valid=4'b1001 -> grant=3 and ptr becomes 0.
REQ-033 Idle drain: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle, with out_data unchanged.
REQ-034 Reset mid-stall: out_valid=1, out_ready=0, rst=1 for 1 cycle -> out_valid=0, ptr=0; with all requesting afterwards, the first grant is 0.

Source files
------------

// File: rtl/mux_arbiter_4.sv
// Four requesters share one 4:1 data mux behind a single registered output
// stage. A rotating priority pointer arbitrates among them round-robin.
module mux_arbiter_4 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_src,
    input  logic           out_ready
);

    logic [1:0]   ptr_r;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic [1:0]   out_src_r;

    logic         load_s;
    logic         any_valid_s;
    logic         accept_s;
    logic         found_s;
    logic [1:0]   grant_s;
    logic [1:0]   idx_s;
    logic [W-1:0] mux_data_s;

    // Round-robin search: first valid requester at ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        grant_s = ptr_r;
        found_s = 1'b0;
        idx_s   = ptr_r;
        for (int k = 0; k < 4; k++) begin
            idx_s   = ptr_r + 2'(k);
            grant_s = (!found_s && in_valid[idx_s]) ? idx_s : grant_s;
            found_s = found_s | in_valid[idx_s];
        end
    end

    // Handshake qualifiers; reset suppresses any acceptance in its cycle.
    always_comb begin
        any_valid_s = |in_valid;
        load_s      = !out_valid_r || out_ready;
        accept_s    = load_s && any_valid_s && !rst;
    end

    // Shared 4:1 data mux steered by the grant.
    always_comb begin
        case (grant_s)
            2'd0:    mux_data_s = in_data[0*W +: W];
            2'd1:    mux_data_s = in_data[1*W +: W];
            2'd2:    mux_data_s = in_data[2*W +: W];
            2'd3:    mux_data_s = in_data[3*W +: W];
            default: mux_data_s = {W{1'b0}};
        endcase
    end

    // One-hot ready toward the granted requester, combinational by design.
    always_comb begin
        in_ready = 4'b0000;
        if (accept_s) begin
            in_ready[grant_s] = 1'b1;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Output register and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= 2'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_src_r   <= 2'd0;
        end else if (load_s) begin
            if (any_valid_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mux_data_s;
                out_src_r   <= grant_s;
                ptr_r       <= grant_s + 2'd1;
            end else begin
                // Drained with nothing to refill: keep the last word visible.
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Self-checking bench for mux_arbiter_4: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_mux_arbiter_4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int           ptr_m;
    bit           ov_m;
    logic [W-1:0] od_m;
    int           os_m;

    mux_arbiter_4 #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int model_grant();
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int g;
        r = 4'b0000;
        if (rst || (ov_m && !out_ready)) return r;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_tick();
        int g;
        if (rst) begin
            ptr_m = 0; ov_m = 1'b0; od_m = '0; os_m = 0;
        end else if (!ov_m || out_ready) begin
            g = model_grant();
            if (g >= 0) begin
                ov_m = 1'b1;
                od_m = in_data[g*W +: W];
                os_m = g;
                ptr_m = (g + 1) % 4;
            end else begin
                ov_m = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [4*W-1:0] d, input logic ordy);
        rst = r; in_valid = v; in_data = d; out_ready = ordy;
    endtask

    task automatic apply_reset();
        drive(1'b1, 4'b0000, '0, 1'b1);
        @(posedge clk); model_tick(); #1;
        drive(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b1111, {$urandom, $urandom} , 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready: got %b want 0000", in_ready);
            end
            @(posedge clk); model_tick(); #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0 || dut.ptr_r !== 2'd0) begin
                errors++;
                $display("FAIL reset_state: got v=%b d=%h s=%0d p=%0d want all 0",
                         out_valid, out_data, out_src, dut.ptr_r);
            end
        end
        drive(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_single();
        logic [4*W-1:0] d;
        d = '0;
        d[2*W +: W] = 8'hA5;
        drive(1'b0, 4'b0100, d, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", in_ready);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2 || dut.ptr_r !== 2'd3) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h s=%0d p=%0d want 1 a5 2 3",
                     out_valid, out_data, out_src, dut.ptr_r);
        end
    endtask

    task automatic test_rotate();
        logic [4*W-1:0] d;
        logic [3:0] exp_r;
        apply_reset();
        for (int i = 0; i < 4; i++) d[i*W +: W] = 8'(8'h10 + i);
        drive(1'b0, 4'b1111, d, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_r = 4'b0001 << (c % 4);
            checks++;
            if (in_ready !== exp_r) begin
                errors++;
                $display("FAIL rotate_ready[%0d]: got %b want %b", c, in_ready, exp_r);
            end
            @(posedge clk); model_tick(); #1;
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== 8'(8'h10 + c % 4)) begin
                errors++;
                $display("FAIL rotate_out[%0d]: got v=%b s=%0d d=%h want 1 %0d %h",
                         c, out_valid, out_src, out_data, c % 4, 8'(8'h10 + c % 4));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_d;
        logic [1:0]   held_s;
        logic [3:0]   exp_r;
        held_d = out_data;
        held_s = out_src;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", c, in_ready);
            end
            @(posedge clk); model_tick(); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_src !== held_s) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%0d want 1 %h %0d",
                         c, out_valid, out_data, out_src, held_d, held_s);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_r = 4'b0001 << ((held_s + 1) % 4);
        checks++;
        if (in_ready !== exp_r) begin
            errors++;
            $display("FAIL release_ready: got %b want %b", in_ready, exp_r);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_src !== 2'((held_s + 1) % 4) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_out: got s=%0d v=%b want %0d 1", out_src, out_valid, (held_s + 1) % 4);
        end
    endtask

    task automatic test_wrap_skip();
        logic [4*W-1:0] d;
        apply_reset();
        d = {8'h44, 8'h33, 8'h22, 8'h11};
        drive(1'b0, 4'b0100, d, 1'b1);
        @(posedge clk); model_tick(); #1;
        in_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ready1: got %b want 0010", in_ready);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_src !== 2'd1 || out_data !== 8'h22 || dut.ptr_r !== 2'd2) begin
            errors++;
            $display("FAIL wrap_out1: got s=%0d d=%h p=%0d want 1 22 2", out_src, out_data, dut.ptr_r);
        end
        in_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready2: got %b want 1000", in_ready);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_src !== 2'd3 || out_data !== 8'h44 || dut.ptr_r !== 2'd0) begin
            errors++;
            $display("FAIL wrap_out2: got s=%0d d=%h p=%0d want 3 44 0", out_src, out_data, dut.ptr_r);
        end
    endtask

    task automatic test_idle_drain();
        logic [W-1:0] held_d;
        held_d = out_data;
        drive(1'b0, 4'b0000, in_data, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL drain_ready: got %b want 0000", in_ready);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== held_d) begin
            errors++;
            $display("FAIL drain_out: got v=%b d=%h want 0 %h", out_valid, out_data, held_d);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 4'b0100, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
        @(posedge clk); model_tick(); #1;
        drive(1'b1, 4'b1111, in_data, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rststall_ready: got %b want 0000", in_ready);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_valid !== 1'b0 || dut.ptr_r !== 2'd0) begin
            errors++;
            $display("FAIL rststall_state: got v=%b p=%0d want 0 0", out_valid, dut.ptr_r);
        end
        drive(1'b0, 4'b1111, in_data, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rststall_grant: got %b want 0001", in_ready);
        end
        @(posedge clk); model_tick(); #1;
        checks++;
        if (out_src !== 2'd0 || out_data !== 8'h01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rststall_out: got s=%0d d=%h v=%b want 0 01 1", out_src, out_data, out_valid);
        end
    endtask

    task automatic test_random();
        int wait_cnt [4];
        logic [3:0] acc;
        logic [3:0] exp_r;
        apply_reset();
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] && ($urandom % 3 == 0)) begin
                    in_valid[i] = 1'b1;
                    in_data[i*W +: W] = 8'($urandom);
                end
            end
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 60) == 0;
            @(negedge clk);
            exp_r = model_ready();
            acc = in_ready;
            checks++;
            if (in_ready !== exp_r) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, exp_r);
            end
            if (rst) begin
                for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
            end else if (exp_r != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (exp_r[i]) begin
                        checks++;
                        if (wait_cnt[i] > 3) begin
                            errors++;
                            $display("FAIL rand_fair[%0d]: lane %0d waited %0d transfers want <=3", c, i, wait_cnt[i]);
                        end
                        wait_cnt[i] = 0;
                    end else if (in_valid[i]) begin
                        wait_cnt[i]++;
                    end
                end
            end
            @(posedge clk); model_tick(); #1;
            checks++;
            if (out_valid !== ov_m || out_data !== od_m || out_src !== 2'(os_m)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want %b %h %0d",
                         c, out_valid, out_data, out_src, ov_m, od_m, os_m);
            end
            in_valid = in_valid & ~exp_r;
        end
        rst = 1'b0;
    endtask

    // Test sequence and summary.
    initial begin
        drive(1'b1, 4'b0000, '0, 1'b1);
        ptr_m = 0; ov_m = 1'b0; od_m = '0; os_m = 0;
        test_reset();
        test_single();
        test_rotate();
        test_backpressure();
        test_wrap_skip();
        test_idle_drain();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
